// File: rtl/johnson_pkg.sv
// Shared Johnson-code helpers and lock FSM types for the decoder and the producer's bench.
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam int ERRCNT_MAX = 255;

  // A legal Johnson pattern has at most one 0/1 boundary between adjacent bits.
  function automatic logic johnson_legal(input logic [31:0] code, input int width);
    int trans;
    trans = 0;
    for (int i = 0; i < 31; i++) begin
      if ((i < width - 1) && (code[i] != code[i+1])) trans++;
    end
    return (trans <= 1);
  endfunction

  function automatic int johnson_idx(input logic [31:0] code, input int width);
    int p;
    p = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) p += int'(code[i]);
    end
    if (p == 0) return 0;
    else if (code[width-1]) return p;
    else return 2 * width - p;
  endfunction

endpackage

// File: rtl/johnson_lock_fsm.sv
// Lock tracker: counts consecutive good successor steps and reports lock status.
//
// state    | meaning
// UNLOCKED | no valid reference (after reset or an illegal sample)
// LOCKING  | reference held, accumulating good steps in streak
// LOCKED   | LOCK_CNT consecutive good steps seen
module johnson_lock_fsm
  import johnson_pkg::*;
#(
  parameter int LOCK_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic        legal,
  input  logic        good,
  output lock_state_t state,
  output logic        locked
);

  logic [3:0] streak;
  logic [3:0] streak_inc;

  assign streak_inc = streak + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= UNLOCKED;
      streak <= '0;
      locked <= 1'b0;
    end else if (sample) begin
      if (!legal) begin
        state  <= UNLOCKED;
        streak <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          UNLOCKED: begin
            state  <= LOCKING;
            streak <= '0;
            locked <= 1'b0;
          end
          LOCKING: begin
            if (good) begin
              streak <= streak_inc;
              if (int'(streak_inc) >= LOCK_CNT) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              streak <= '0;
            end
          end
          LOCKED: begin
            if (!good) begin
              state  <= LOCKING;
              streak <= '0;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= UNLOCKED;
            streak <= '0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson phase-bus receiver: binary index, legality/successor checks, lock and error count.
// Define JOHNSON_DECODER_ERRCNT_EN to implement err_cnt; otherwise it is tied to 0.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int IDX_W    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_vld,
  input  logic [WIDTH-1:0] code_i,
  output logic [IDX_W-1:0] idx,
  output logic             idx_vld,
  output logic             illegal,
  output logic             skip,
  output logic             wrap,
  output logic             locked,
  output logic [7:0]       err_cnt
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(2 * WIDTH - 1);

  logic [31:0]      code_ext;
  logic             legal;
  logic [IDX_W-1:0] idx_new;
  logic [IDX_W-1:0] succ;
  logic             ref_valid;
  logic             good;
  logic             skip_n;
  lock_state_t      state;

  assign code_ext = 32'(code_i);
  assign legal    = johnson_legal(code_ext, WIDTH);
  assign idx_new  = IDX_W'(johnson_idx(code_ext, WIDTH));
  assign succ     = (idx == LAST) ? '0 : idx + IDX_W'(1);

  // idx doubles as the reference; it is only meaningful outside UNLOCKED.
  assign ref_valid = (state != UNLOCKED);
  assign good      = code_vld & legal & ref_valid & (idx_new == succ);
  assign skip_n    = code_vld & legal & ref_valid & ~good;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      idx_vld <= 1'b0;
      illegal <= 1'b0;
      skip    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      idx_vld <= code_vld & legal;
      illegal <= code_vld & ~legal;
      skip    <= skip_n;
      wrap    <= good & (idx == LAST);
      if (code_vld && legal) idx <= idx_new;
    end
  end

  johnson_lock_fsm #(
    .LOCK_CNT(LOCK_CNT)
  ) u_lock_fsm (
    .clk   (clk),
    .rst   (rst),
    .sample(code_vld),
    .legal (legal),
    .good  (good),
    .state (state),
    .locked(locked)
  );

`ifdef JOHNSON_DECODER_ERRCNT_EN
  logic err_inc;
  assign err_inc = (code_vld & ~legal) | skip_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt <= '0;
    else if (err_inc && (err_cnt != 8'(ERRCNT_MAX))) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder (WIDTH=4, LOCK_CNT=3), directed vectors.
module tb_johnson_decoder;

  logic       clk;
  logic       rst;
  logic       code_vld;
  logic [3:0] code_i;
  logic [2:0] idx;
  logic       idx_vld, illegal, skip, wrap, locked;
  logic [7:0] err_cnt;

  typedef struct packed {
    logic [2:0] idx;
    logic       vld;
    logic       ill;
    logic       skp;
    logic       wrp;
    logic       lck;
    logic [7:0] err;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  johnson_decoder #(.WIDTH(4), .LOCK_CNT(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .code_vld(code_vld),
    .code_i  (code_i),
    .idx     (idx),
    .idx_vld (idx_vld),
    .illegal (illegal),
    .skip    (skip),
    .wrap    (wrap),
    .locked  (locked),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xerr(input int e);
`ifdef JOHNSON_DECODER_ERRCNT_EN
    return (e > 255) ? 8'd255 : 8'(e);
`else
    return (e > 255) ? 8'd0 : 8'd0;
`endif
  endfunction

  function automatic obs_t actual();
    return '{idx: idx, vld: idx_vld, ill: illegal, skp: skip, wrp: wrap, lck: locked, err: err_cnt};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got idx=%0d vld=%b ill=%b skip=%b wrap=%b lock=%b err=%0d, want idx=%0d vld=%b ill=%b skip=%b wrap=%b lock=%b err=%0d",
                  name, got.idx, got.vld, got.ill, got.skp, got.wrp, got.lck, got.err,
                  want.idx, want.vld, want.ill, want.skp, want.wrp, want.lck, want.err);
  endtask

  // Monitor: outputs are presented every cycle after a sample; pop and compare.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("sample", actual(), exp_q.pop_front());
  end

  task automatic step(input logic vld, input logic [3:0] code, input logic [2:0] e_idx,
                      input logic e_v, input logic e_i, input logic e_s, input logic e_w,
                      input logic e_l, input int e_err);
    @(negedge clk);
    code_vld = vld;
    code_i   = code;
    exp_q.push_back('{idx: e_idx, vld: e_v, ill: e_i, skp: e_s, wrp: e_w, lck: e_l, err: xerr(e_err)});
  endtask

  initial begin
    rst      = 1'b1;
    code_vld = 1'b0;
    code_i   = 4'b0000;
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", actual(), '0);
    @(negedge clk);
    rst = 1'b0;

    // Acquire lock from the producer's reset value.
    step(1, 4'b0001, 7, 1, 0, 0, 0, 0, 0);
    step(1, 4'b0000, 0, 1, 0, 0, 1, 0, 0);
    step(1, 4'b1000, 1, 1, 0, 0, 0, 0, 0);
    step(1, 4'b1100, 2, 1, 0, 0, 0, 1, 0);
    // Illegal while locked, then first legal sample is not a skip.
    step(1, 4'b0101, 2, 0, 1, 0, 0, 0, 1);
    step(1, 4'b1110, 3, 1, 0, 0, 0, 0, 1);
    step(1, 4'b1111, 4, 1, 0, 0, 0, 0, 1);
    step(1, 4'b0111, 5, 1, 0, 0, 0, 0, 1);
    step(1, 4'b0011, 6, 1, 0, 0, 0, 1, 1);
    step(1, 4'b0001, 7, 1, 0, 0, 0, 1, 1);
    step(1, 4'b0000, 0, 1, 0, 0, 1, 1, 1);
    step(1, 4'b1000, 1, 1, 0, 0, 0, 1, 1);
    // Skip forward from idx 1 to idx 3, then re-lock.
    step(1, 4'b1110, 3, 1, 0, 1, 0, 0, 2);
    step(1, 4'b1111, 4, 1, 0, 0, 0, 0, 2);
    step(1, 4'b0111, 5, 1, 0, 0, 0, 0, 2);
    step(1, 4'b0011, 6, 1, 0, 0, 0, 1, 2);
    // Idle cycles carrying garbage must not disturb anything.
    step(0, 4'b0101, 6, 0, 0, 0, 0, 1, 2);
    step(1, 4'b0001, 7, 1, 0, 0, 0, 1, 2);
    step(0, 4'b1010, 7, 0, 0, 0, 0, 1, 2);
    step(0, 4'b0000, 7, 0, 0, 0, 0, 1, 2);
    step(1, 4'b0000, 0, 1, 0, 0, 1, 1, 2);
    // Repeated index is a skip.
    step(1, 4'b0000, 0, 1, 0, 1, 0, 0, 3);
    // Saturation of the error counter.
    for (int i = 1; i <= 300; i++) step(1, 4'b1010, 0, 0, 1, 0, 0, 0, 3 + i);
    step(1, 4'b0001, 7, 1, 0, 0, 0, 0, 303);
    step(1, 4'b0000, 0, 1, 0, 0, 1, 0, 303);
    step(1, 4'b1000, 1, 1, 0, 0, 0, 0, 303);
    step(1, 4'b1100, 2, 1, 0, 0, 0, 1, 303);
    step(0, 4'b0000, 2, 0, 0, 0, 0, 1, 303);
    step(1, 4'b1110, 3, 1, 0, 0, 0, 1, 303);

    // Asynchronous reset mid-cycle while locked.
    @(negedge clk);
    code_vld = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", actual(), '0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 4'b0011, 6, 1, 0, 0, 0, 0, 0);
    step(1, 4'b0001, 7, 1, 0, 0, 0, 0, 0);
    step(0, 4'b0000, 7, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    code_vld = 1'b0;

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Decodes and checks the 2·WIDTH-state twisted-ring (Johnson) code produced by the team's ring counter. Each valid sample is converted to a binary phase index, checked for code legality and correct successor ordering, and tracked by a lock state machine. The block sits at the receiving end of a Johnson-coded phase bus. It supplies a clean binary phase, lock status and error statistics to downstream control logic.

## Interface
- WIDTH, 4: Johnson code width; sequence length 2·WIDTH; WIDTH ≥ 2.
- LOCK_CNT, 3: consecutive good successor steps required to declare lock; 1..15.
- IDX_W, $clog2(2·WIDTH): width of the phase index.
- clk  in  1  clock; all state updates occur on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- code_vld  in  1  sample strobe; code_i is evaluated only when this is high.
- code_i  in  WIDTH  Johnson code sample.
- idx  out  IDX_W  decoded phase index; registered.
- idx_vld  out  1  one-cycle pulse: idx updated from a legal code.
- illegal  out  1  one-cycle pulse: sample was not a legal Johnson pattern.
- skip  out  1  one-cycle pulse: sample was legal but not the successor of the reference.
- wrap  out  1  one-cycle pulse: good step from index 2·WIDTH−1 to index 0.
- locked  out  1  level; high while the FSM is in LOCKED.
- err_cnt  out  8  saturating count of illegal and skip events.

## Operation
- Producer sequence for WIDTH=4, starting from its reset value: 0001 → 0000 → 1000 → 1100 → 1110 → 1111 → 0111 → 0011 → 0001 …
- Index mapping:
  - Code 0…0 is index 0.
  - MSB=1: index = popcount.
  - MSB=0 and code nonzero: index = 2·WIDTH − popcount.
  - Resulting WIDTH=4 map: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
- Legal code: a contiguous run of ones anchored at the MSB, or anchored at the LSB, or all zeros. Any other pattern is illegal.
- Reference: the index of the last legal sample, plus a ref_valid flag. ref_valid is cleared by reset and by any illegal sample.
- Good step: legal sample with ref_valid=1 and index == (ref+1) mod 2·WIDTH. A repeated index is a skip.
- FSM states: UNLOCKED, LOCKING, LOCKED. Reset state is UNLOCKED.
  - UNLOCKED: a legal sample loads the reference and moves to LOCKING with streak=0. An illegal sample stays in UNLOCKED.
  - LOCKING: a good step increments streak. When streak reaches LOCK_CNT, move to LOCKED. A skip reloads the reference and sets streak=0, staying in LOCKING. An illegal sample moves to UNLOCKED.
  - LOCKED: a good step stays in LOCKED. A skip moves to LOCKING with streak=0. An illegal sample moves to UNLOCKED.
- Samples with code_vld=0 change nothing. The pulse outputs are low in those cycles.

## Timing
- Latency: one cycle from the sampling edge to idx, idx_vld, illegal, skip, wrap, and to updates of locked and err_cnt.
- Reset values of all outputs: idx=0, idx_vld=0, illegal=0, skip=0, wrap=0, locked=0, err_cnt=0. Internal state on reset: ref_valid=0, streak=0.
- Reset is asynchronous and clears everything immediately, including in mid-stream or while LOCKED.
- An illegal sample asserts illegal only; idx holds its previous value and idx_vld stays low.
- A skip asserts both idx_vld and skip, and idx shows the new index.
- The first legal sample after reset or after an illegal sample asserts idx_vld only. It is never a skip and never a wrap.
- err_cnt saturates at 255. At most one increment per sample.

## Configuration
- JOHNSON_DECODER_ERRCNT_EN defined: err_cnt counter implemented as specified.
- JOHNSON_DECODER_ERRCNT_EN undefined: no counter is implemented and err_cnt is tied to 0. All other behaviour is identical.

## Structure
- Shared package johnson_pkg holds:
  - the FSM state enum (UNLOCKED, LOCKING, LOCKED);
  - the ERRCNT_MAX=255 constant;
  - the johnson_idx and johnson_legal functions, shared with the producer's testbench.
- One sub-module, johnson_lock_fsm, holds the state and streak registers. Its inputs are legal, good and sample; its outputs are state and locked.

## Test plan
All scenarios use WIDTH=4 and LOCK_CNT=3.
- Release reset, then feed 0001, 0000, 1000, 1100 on consecutive cycles with code_vld=1:
  - idx = 7, 0, 1, 2, with idx_vld pulsed each cycle;
  - wrap pulses on the 0000 result;
  - locked rises one cycle after the 1100 sample.
- While locked, feed 0101: illegal=1, idx_vld=0, idx holds 2; next cycle locked=0, err_cnt=1. Follow with 1110: idx=3, no skip (reference was cleared).
- While locked at idx 1, feed 1110: idx=3, idx_vld=1, skip=1, locked=0, err_cnt increments; three further good steps re-lock.
- Interleave code_vld=0 cycles carrying garbage on code_i within a good sequence: no pulses, no state change, lock is retained.
- Apply 300 illegal samples: err_cnt stops at 255. With the macro undefined, err_cnt stays 0 throughout.
- Assert rst asynchronously mid-cycle while LOCKED: all outputs go to 0 before the next clock edge, and the first sample after release produces no skip.
